// File: rtl/armleocpu_axi_read_arbiter.sv
// 2:1 round-robin arbiter sharing one downstream AXI4 read port (AR+R) between two hosts.
// One burst in flight; R beats are steered to the granted host until RLAST.
module armleocpu_axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  h0_axi_arvalid,
  output logic                  h0_axi_arready,
  input  logic [ADDR_WIDTH-1:0] h0_axi_araddr,
  input  logic [7:0]            h0_axi_arlen,
  input  logic [2:0]            h0_axi_arsize,
  input  logic [1:0]            h0_axi_arburst,
  input  logic                  h0_axi_arlock,
  input  logic [ID_WIDTH-1:0]   h0_axi_arid,
  input  logic [2:0]            h0_axi_arprot,
  output logic                  h0_axi_rvalid,
  input  logic                  h0_axi_rready,
  output logic [DATA_WIDTH-1:0] h0_axi_rdata,
  output logic [1:0]            h0_axi_rresp,
  output logic [ID_WIDTH-1:0]   h0_axi_rid,
  output logic                  h0_axi_rlast,

  input  logic                  h1_axi_arvalid,
  output logic                  h1_axi_arready,
  input  logic [ADDR_WIDTH-1:0] h1_axi_araddr,
  input  logic [7:0]            h1_axi_arlen,
  input  logic [2:0]            h1_axi_arsize,
  input  logic [1:0]            h1_axi_arburst,
  input  logic                  h1_axi_arlock,
  input  logic [ID_WIDTH-1:0]   h1_axi_arid,
  input  logic [2:0]            h1_axi_arprot,
  output logic                  h1_axi_rvalid,
  input  logic                  h1_axi_rready,
  output logic [DATA_WIDTH-1:0] h1_axi_rdata,
  output logic [1:0]            h1_axi_rresp,
  output logic [ID_WIDTH-1:0]   h1_axi_rid,
  output logic                  h1_axi_rlast,

  output logic                  ds_axi_arvalid,
  input  logic                  ds_axi_arready,
  output logic [ADDR_WIDTH-1:0] ds_axi_araddr,
  output logic [7:0]            ds_axi_arlen,
  output logic [2:0]            ds_axi_arsize,
  output logic [1:0]            ds_axi_arburst,
  output logic                  ds_axi_arlock,
  output logic [ID_WIDTH-1:0]   ds_axi_arid,
  output logic [2:0]            ds_axi_arprot,
  input  logic                  ds_axi_rvalid,
  output logic                  ds_axi_rready,
  input  logic [DATA_WIDTH-1:0] ds_axi_rdata,
  input  logic [1:0]            ds_axi_rresp,
  input  logic [ID_WIDTH-1:0]   ds_axi_rid,
  input  logic                  ds_axi_rlast
);

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_ADDR = 2'd1;
  localparam logic [1:0] STATE_DATA = 2'd2;

  logic [1:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;

  logic       sel_arvalid_s;
  logic       sel_rready_s;

  assign sel_arvalid_s = grant_q ? h1_axi_arvalid : h0_axi_arvalid;
  assign sel_rready_s  = grant_q ? h1_axi_rready  : h0_axi_rready;

  // State register; last_grant resets to 1 so host 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= STATE_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state logic: arbitration in IDLE, AR handshake in ADDR, RLAST in DATA.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      STATE_IDLE: begin
        if (h0_axi_arvalid && h1_axi_arvalid) begin
          grant_d = ~last_grant_q;
          state_d = STATE_ADDR;
        end else if (h0_axi_arvalid) begin
          grant_d = 1'b0;
          state_d = STATE_ADDR;
        end else if (h1_axi_arvalid) begin
          grant_d = 1'b1;
          state_d = STATE_ADDR;
        end else begin
          state_d = STATE_IDLE;
        end
      end
      STATE_ADDR: begin
        if (sel_arvalid_s && ds_axi_arready) begin
          state_d = STATE_DATA;
        end else begin
          state_d = STATE_ADDR;
        end
      end
      STATE_DATA: begin
        // Beat count is never tracked; only RLAST closes the burst.
        if (ds_axi_rvalid && sel_rready_s && ds_axi_rlast) begin
          state_d      = STATE_IDLE;
          last_grant_d = grant_q;
        end else begin
          state_d = STATE_DATA;
        end
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  // Output logic: AR fields follow the grant mux, R payload is broadcast, handshakes gated by state.
  always_comb begin
    ds_axi_araddr  = grant_q ? h1_axi_araddr  : h0_axi_araddr;
    ds_axi_arlen   = grant_q ? h1_axi_arlen   : h0_axi_arlen;
    ds_axi_arsize  = grant_q ? h1_axi_arsize  : h0_axi_arsize;
    ds_axi_arburst = grant_q ? h1_axi_arburst : h0_axi_arburst;
    ds_axi_arlock  = grant_q ? h1_axi_arlock  : h0_axi_arlock;
    ds_axi_arid    = grant_q ? h1_axi_arid    : h0_axi_arid;
    ds_axi_arprot  = grant_q ? h1_axi_arprot  : h0_axi_arprot;

    h0_axi_rdata = ds_axi_rdata;
    h0_axi_rresp = ds_axi_rresp;
    h0_axi_rid   = ds_axi_rid;
    h0_axi_rlast = ds_axi_rlast;
    h1_axi_rdata = ds_axi_rdata;
    h1_axi_rresp = ds_axi_rresp;
    h1_axi_rid   = ds_axi_rid;
    h1_axi_rlast = ds_axi_rlast;

    ds_axi_arvalid = 1'b0;
    ds_axi_rready  = 1'b0;
    h0_axi_arready = 1'b0;
    h1_axi_arready = 1'b0;
    h0_axi_rvalid  = 1'b0;
    h1_axi_rvalid  = 1'b0;

    case (state_q)
      STATE_IDLE: begin
        ds_axi_arvalid = 1'b0;
      end
      STATE_ADDR: begin
        ds_axi_arvalid = sel_arvalid_s;
        h0_axi_arready = grant_q ? 1'b0 : ds_axi_arready;
        h1_axi_arready = grant_q ? ds_axi_arready : 1'b0;
      end
      STATE_DATA: begin
        ds_axi_rready = sel_rready_s;
        h0_axi_rvalid = grant_q ? 1'b0 : ds_axi_rvalid;
        h1_axi_rvalid = grant_q ? ds_axi_rvalid : 1'b0;
      end
      default: begin
        ds_axi_arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_armleocpu_axi_read_arbiter.sv
// Scoreboard bench for armleocpu_axi_read_arbiter: directed requests push expected AR/R
// records into queues; a negedge monitor pops and compares on every handshake.
module tb_armleocpu_axi_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]  h_arvalid = 2'b00;
  logic [1:0]  h_arready, h_rvalid, h_rlast;
  logic [1:0]  h_rready = 2'b11;
  logic [31:0] h_araddr [2];
  logic [7:0]  h_arlen [2];
  logic [2:0]  h_arprot [2];
  logic [3:0]  h_arid [2];
  logic [3:0]  h_rid [2];
  logic [31:0] h_rdata [2];
  logic [1:0]  h_rresp [2];

  logic        ds_arvalid, ds_rready, ds_arlock;
  logic        ds_arready = 1'b0;
  logic [31:0] ds_araddr;
  logic [7:0]  ds_arlen;
  logic [2:0]  ds_arsize, ds_arprot;
  logic [1:0]  ds_arburst;
  logic [3:0]  ds_arid;
  logic        ds_rvalid = 1'b0;
  logic        ds_rlast = 1'b0;
  logic [31:0] ds_rdata = 32'h0;
  logic [1:0]  ds_rresp = 2'b00;
  logic [3:0]  ds_rid = 4'h0;

  armleocpu_axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .h0_axi_arvalid(h_arvalid[0]), .h0_axi_arready(h_arready[0]), .h0_axi_araddr(h_araddr[0]),
    .h0_axi_arlen(h_arlen[0]), .h0_axi_arsize(3'd2), .h0_axi_arburst(2'd1), .h0_axi_arlock(1'b0),
    .h0_axi_arid(h_arid[0]), .h0_axi_arprot(h_arprot[0]),
    .h0_axi_rvalid(h_rvalid[0]), .h0_axi_rready(h_rready[0]), .h0_axi_rdata(h_rdata[0]),
    .h0_axi_rresp(h_rresp[0]), .h0_axi_rid(h_rid[0]), .h0_axi_rlast(h_rlast[0]),
    .h1_axi_arvalid(h_arvalid[1]), .h1_axi_arready(h_arready[1]), .h1_axi_araddr(h_araddr[1]),
    .h1_axi_arlen(h_arlen[1]), .h1_axi_arsize(3'd2), .h1_axi_arburst(2'd1), .h1_axi_arlock(1'b0),
    .h1_axi_arid(h_arid[1]), .h1_axi_arprot(h_arprot[1]),
    .h1_axi_rvalid(h_rvalid[1]), .h1_axi_rready(h_rready[1]), .h1_axi_rdata(h_rdata[1]),
    .h1_axi_rresp(h_rresp[1]), .h1_axi_rid(h_rid[1]), .h1_axi_rlast(h_rlast[1]),
    .ds_axi_arvalid(ds_arvalid), .ds_axi_arready(ds_arready), .ds_axi_araddr(ds_araddr),
    .ds_axi_arlen(ds_arlen), .ds_axi_arsize(ds_arsize), .ds_axi_arburst(ds_arburst),
    .ds_axi_arlock(ds_arlock), .ds_axi_arid(ds_arid), .ds_axi_arprot(ds_arprot),
    .ds_axi_rvalid(ds_rvalid), .ds_axi_rready(ds_rready), .ds_axi_rdata(ds_rdata),
    .ds_axi_rresp(ds_rresp), .ds_axi_rid(ds_rid), .ds_axi_rlast(ds_rlast)
  );

  typedef struct {int host; logic [31:0] addr; logic [7:0] len; logic [3:0] id;} ar_exp_t;
  typedef struct {int host; logic [31:0] data; logic last; logic [3:0] id;} r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  ar_exp_t req_q0[$];
  ar_exp_t req_q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Values sampled by the monitor at negedge, consumed by drivers at posedge+1.
  int          cyc = 0;
  logic        rst_seen = 1'b1;
  logic [1:0]  ar_fire = 2'b00;
  logic        ds_ar_fire = 1'b0, ds_r_fire = 1'b0, ds_arvalid_seen = 1'b0;
  logic        ds_arvalid_prev = 1'b0;
  logic [1:0]  h_arvalid_prev = 2'b00;
  logic [31:0] lat_addr = 32'h0;
  logic [7:0]  lat_len = 8'h0;
  logic [3:0]  lat_id = 4'h0;
  int          arv_rise_cyc = 0;
  int          h_arv_rise_cyc [2] = '{0, 0};
  int          r_hs_cyc [2] = '{0, 0};
  int          r_cnt [2] = '{0, 0};
  int          ar_stall_seen = 0;
  int          ar_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input int host, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] id);
    ar_exp_t a;
    r_exp_t  r;
    a.host = host; a.addr = addr; a.len = len; a.id = id;
    if (host == 0) req_q0.push_back(a);
    else req_q1.push_back(a);
    ar_q.push_back(a);
    for (int k = 0; k <= int'(len); k++) begin
      r.host = host; r.data = addr + 32'(k); r.last = (k == int'(len)); r.id = id;
      r_q.push_back(r);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      done = (ar_q.size() == 0) && (r_q.size() == 0) && (req_q0.size() == 0) && (req_q1.size() == 0);
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout, ar_q=%0d r_q=%0d pending", name, ar_q.size(), r_q.size());
      ar_q.delete(); r_q.delete(); req_q0.delete(); req_q1.delete();
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_beats(input int host, input int target, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); #1;
      done = (r_cnt[host] >= target);
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout, beats got %0d expected %0d", name, r_cnt[host], target);
    end
  endtask

  task automatic host_drv(input int h);
    ar_exp_t r;
    bit have;
    forever begin
      @(posedge clk); #1;
      if (rst_seen || ar_fire[h]) h_arvalid[h] = 1'b0;
      have = 1'b0;
      if (!h_arvalid[h] && !rst_seen) begin
        if (h == 0 && req_q0.size() > 0) begin r = req_q0.pop_front(); have = 1'b1; end
        else if (h == 1 && req_q1.size() > 0) begin r = req_q1.pop_front(); have = 1'b1; end
      end
      if (have) begin
        h_araddr[h]  = r.addr;
        h_arlen[h]   = r.len;
        h_arid[h]    = r.id;
        h_arprot[h]  = (h == 1) ? 3'd2 : 3'd0;
        h_arvalid[h] = 1'b1;
      end
    end
  endtask

  initial host_drv(0);
  initial host_drv(1);

  // Downstream slave: returns len+1 beats with data = araddr + beat index.
  initial begin : slave
    bit          active = 1'b0;
    int          beat = 0;
    logic [31:0] cur_addr = 32'h0;
    logic [7:0]  cur_len = 8'h0;
    logic [3:0]  cur_id = 4'h0;
    forever begin
      @(posedge clk); #1;
      if (rst_seen) begin
        active = 1'b0;
      end else begin
        if (ds_r_fire) begin
          if (ds_rlast) active = 1'b0;
          else beat++;
        end
        if (ds_ar_fire) begin
          active = 1'b1; beat = 0; cur_addr = lat_addr; cur_len = lat_len; cur_id = lat_id;
        end
        if (ds_arvalid_seen && ar_stall > 0) ar_stall--;
      end
      ds_arready = (ar_stall == 0);
      ds_rvalid  = active;
      ds_rdata   = cur_addr + 32'(beat);
      ds_rlast   = (beat == int'(cur_len));
      ds_rid     = cur_id;
      ds_rresp   = 2'b00;
    end
  end

  // Monitor: scoreboard pops on AR/R handshakes, plus stall-stability checks.
  initial begin : monitor
    ar_exp_t a;
    r_exp_t  e;
    forever begin
      @(negedge clk);
      cyc++;
      rst_seen        = rst;
      ar_fire         = h_arvalid & h_arready;
      ds_ar_fire      = ds_arvalid && ds_arready;
      ds_r_fire       = ds_rvalid && ds_rready;
      ds_arvalid_seen = ds_arvalid;
      lat_addr = ds_araddr; lat_len = ds_arlen; lat_id = ds_arid;
      if (ds_arvalid && !ds_arvalid_prev) arv_rise_cyc = cyc;
      for (int h = 0; h < 2; h++)
        if (h_arvalid[h] && !h_arvalid_prev[h]) h_arv_rise_cyc[h] = cyc;
      ds_arvalid_prev = ds_arvalid;
      h_arvalid_prev  = h_arvalid;
      if (!rst) begin
        if (ds_arvalid) begin
          if (ar_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ar_unexpected: got ds_arvalid=1 addr 0x%0h expected no request", ds_araddr);
          end else begin
            a = ar_q[0];
            chk("ar_addr", 64'(ds_araddr), 64'(a.addr));
            chk("ar_len", 64'(ds_arlen), 64'(a.len));
            chk("ar_id", 64'(ds_arid), 64'(a.id));
            chk("ar_prot", 64'(ds_arprot), (a.host == 1) ? 64'd2 : 64'd0);
            chk("arready_other", 64'(h_arready[1-a.host]), 64'd0);
            chk("arready_grant", 64'(h_arready[a.host]), 64'(ds_arready));
            if (ds_arready) void'(ar_q.pop_front());
            else ar_stall_seen++;
          end
        end
        if (ds_rvalid && r_q.size() > 0)
          chk("ds_rready", 64'(ds_rready), 64'(h_rready[r_q[0].host]));
        for (int h = 0; h < 2; h++) begin
          if (h_rvalid[h]) begin
            if (r_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL r_unexpected: got rvalid on host %0d expected none", h);
            end else begin
              e = r_q[0];
              chk("r_host", 64'(h), 64'(e.host));
              chk("r_data", 64'(h_rdata[h]), 64'(e.data));
              chk("r_last", 64'(h_rlast[h]), 64'(e.last));
              chk("r_id", 64'(h_rid[h]), 64'(e.id));
              chk("rvalid_other", 64'(h_rvalid[1-h]), 64'd0);
              if (h_rready[h]) begin
                void'(r_q.pop_front());
                r_cnt[h]++;
                r_hs_cyc[h] = cyc;
              end
            end
          end
        end
      end
    end
  end

  initial begin : main
    int base;
    int stalls;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 64'(h_arready), 64'd0);
    chk("rst_rvalid", 64'(h_rvalid), 64'd0);
    chk("rst_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("rst_ds_rready", 64'(ds_rready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Both hosts request continuously from reset: grants alternate 0,1,0,1.
    @(negedge clk); #1;
    issue(0, 32'h0000_0200, 8'd1, 4'd2);
    issue(1, 32'h0000_1200, 8'd2, 4'd5);
    issue(0, 32'h0000_0300, 8'd1, 4'd3);
    issue(1, 32'h0000_1300, 8'd0, 4'd6);
    wait_done(400, "t_round_robin");

    // Host 0 alone, 4-beat burst; AR reaches downstream one cycle after request.
    base = r_cnt[0];
    issue(0, 32'h0000_0100, 8'd3, 4'd1);
    wait_done(200, "t_host0_only");
    chk("t1_beats_h0", 64'(r_cnt[0] - base), 64'd4);
    chk("t1_ar_latency", 64'(arv_rise_cyc - h_arv_rise_cyc[0]), 64'd1);

    // Downstream holds arready low for 3 cycles in ADDR.
    stalls = ar_stall_seen;
    ar_stall = 3;
    issue(1, 32'h0000_2000, 8'd1, 4'd8);
    wait_done(200, "t_ar_stall");
    chk("t4_stall_cycles", 64'(ar_stall_seen - stalls), 64'd3);

    // Host 1 drops rready for 5 cycles after 2 beats.
    base = r_cnt[1];
    issue(1, 32'h0000_3000, 8'd3, 4'd7);
    wait_beats(1, base + 2, "t_rready_stall_wait");
    @(posedge clk); #1;
    h_rready[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    h_rready[1] = 1'b1;
    wait_done(200, "t_rready_stall");
    chk("t3_beats_h1", 64'(r_cnt[1] - base), 64'd4);

    // Single-beat burst, next request's AR appears 2 cycles after the beat.
    issue(0, 32'h0000_4000, 8'd0, 4'd9);
    for (int i = 0; i < 50 && ar_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    issue(1, 32'h0000_5000, 8'd0, 4'd10);
    wait_done(200, "t_single_beat");
    chk("t6_gap", 64'(arv_rise_cyc - r_hs_cyc[0]), 64'd2);

    // Reset in DATA after 2 of 4 beats.
    base = r_cnt[0];
    issue(0, 32'h0000_6000, 8'd3, 4'd4);
    wait_beats(0, base + 2, "t_reset_wait");
    @(posedge clk); #1;
    rst = 1'b1;
    h_rready[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    h_rready[0] = 1'b1;
    r_q.delete();
    @(negedge clk);
    chk("t5_arready", 64'(h_arready), 64'd0);
    chk("t5_rvalid", 64'(h_rvalid), 64'd0);
    chk("t5_ds_arvalid", 64'(ds_arvalid), 64'd0);
    chk("t5_ds_rready", 64'(ds_rready), 64'd0);
    #1;
    // last_grant is 1 again, so host 0 wins the tie.
    issue(0, 32'h0000_7000, 8'd1, 4'd11);
    issue(1, 32'h0000_7100, 8'd1, 4'd12);
    wait_done(200, "t_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
